// File: rtl/xif_initiator_pkg.sv
// Shared types and AES32 encoding constants for the XIF offload initiator.
package xif_initiator_pkg;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_ISSUE       = 3'd1,
      ST_COMMIT      = 3'd2,
      ST_WAIT_RESULT = 3'd3,
      ST_RESP        = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      STATUS_OK      = 2'd0,
      STATUS_ILLEGAL = 2'd1,
      STATUS_KILLED  = 2'd2,
      STATUS_TIMEOUT = 2'd3
   } status_e;

   localparam logic [6:0] OPCODE_OP       = 7'b0110011;
   localparam logic [2:0] FUNCT3_AES32    = 3'b000;
   localparam logic [4:0] FUNCT5_AES32ESI  = 5'b10001;
   localparam logic [4:0] FUNCT5_AES32ESMI = 5'b10011;
   localparam logic [4:0] FUNCT5_AES32DSI  = 5'b10101;
   localparam logic [4:0] FUNCT5_AES32DSMI = 5'b10111;

   // True for any of the four AES32 encodings (bs field in [31:30] is free).
   function automatic logic is_aes32(input logic [31:0] instr);
      logic f5_ok;
      f5_ok = (instr[29:25] == FUNCT5_AES32ESI)  || (instr[29:25] == FUNCT5_AES32ESMI) ||
              (instr[29:25] == FUNCT5_AES32DSI)  || (instr[29:25] == FUNCT5_AES32DSMI);
      return (instr[6:0] == OPCODE_OP) && (instr[14:12] == FUNCT3_AES32) && f5_ok;
   endfunction

endpackage

// File: rtl/xif_offload_initiator.sv
// CPU-side XIF initiator: one transaction at a time through issue, commit,
// result collection and a writeback response with status.
module xif_offload_initiator
   import xif_initiator_pkg::*;
#(
   parameter int unsigned X_ID_WIDTH     = 4,
   parameter int unsigned X_RFR_WIDTH    = 32,
   parameter int unsigned X_RFW_WIDTH    = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic                     req_valid_i,
   output logic                     req_ready_o,
   input  logic [31:0]              req_instr_i,
   input  logic [X_RFR_WIDTH-1:0]   req_rs1_i,
   input  logic [X_RFR_WIDTH-1:0]   req_rs2_i,
   input  logic                     req_kill_i,
   output logic                     issue_valid_o,
   input  logic                     issue_ready_i,
   output logic [31:0]              issue_instr_o,
   output logic [X_ID_WIDTH-1:0]    issue_id_o,
   output logic [2*X_RFR_WIDTH-1:0] issue_rs_o,
   output logic [1:0]               issue_rs_valid_o,
   input  logic                     issue_accept_i,
   input  logic                     issue_writeback_i,
   output logic                     commit_valid_o,
   output logic [X_ID_WIDTH-1:0]    commit_id_o,
   output logic                     commit_kill_o,
   input  logic                     result_valid_i,
   output logic                     result_ready_o,
   input  logic [X_ID_WIDTH-1:0]    result_id_i,
   input  logic [X_RFW_WIDTH-1:0]   result_data_i,
   input  logic [4:0]               result_rd_i,
   input  logic                     result_we_i,
   output logic                     rsp_valid_o,
   input  logic                     rsp_ready_i,
   output logic [1:0]               rsp_status_o,
   output logic [4:0]               rsp_rd_o,
   output logic [X_RFW_WIDTH-1:0]   rsp_data_o,
   output logic                     rsp_we_o,
   output logic                     id_err_o
);

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_e                   state_q, state_d;
   status_e                  status_q, status_d;
   logic [X_ID_WIDTH-1:0]    id_q, id_d;
   logic [15:0]              tmo_q, tmo_d;
   logic [31:0]              instr_q, instr_d;
   logic [X_RFR_WIDTH-1:0]   rs1_q, rs1_d, rs2_q, rs2_d;
   logic                     kill_q, kill_d;
   logic                     accept_q, accept_d;
   logic                     wb_q, wb_d;
   logic [4:0]               rd_q, rd_d;
   logic [X_RFW_WIDTH-1:0]   data_q, data_d;
   logic                     we_q, we_d;
   logic                     id_err_q, id_err_d;

   logic st_issue, st_commit, st_wait, st_resp, commit_kill;

   always_comb begin
      state_d  = state_q;
      status_d = status_q;
      id_d     = id_q;
      tmo_d    = tmo_q;
      instr_d  = instr_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      kill_d   = kill_q;
      accept_d = accept_q;
      wb_d     = wb_q;
      rd_d     = rd_q;
      data_d   = data_q;
      we_d     = we_q;
      id_err_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (req_valid_i) begin
               instr_d = req_instr_i;
               rs1_d   = req_rs1_i;
               rs2_d   = req_rs2_i;
               kill_d  = req_kill_i;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (issue_ready_i) begin
               accept_d = issue_accept_i;
               wb_d     = issue_writeback_i;
               state_d  = ST_COMMIT;
            end
         end
         ST_COMMIT: begin
            if (!accept_q || kill_q) begin
               // A rejected instruction reports ILLEGAL even if it was also flushed.
               status_d = accept_q ? STATUS_KILLED : STATUS_ILLEGAL;
               rd_d     = 5'd0;
               data_d   = '0;
               we_d     = 1'b0;
               state_d  = ST_RESP;
            end else begin
               tmo_d   = 16'd0;
               state_d = ST_WAIT_RESULT;
            end
         end
         ST_WAIT_RESULT: begin
            if (result_valid_i && result_id_i == id_q) begin
               status_d = STATUS_OK;
               rd_d     = result_rd_i;
               data_d   = result_data_i;
               we_d     = result_we_i & wb_q;
               state_d  = ST_RESP;
            end else if (tmo_q == TMO_LAST) begin
               status_d = STATUS_TIMEOUT;
               rd_d     = 5'd0;
               data_d   = '0;
               we_d     = 1'b0;
               state_d  = ST_RESP;
            end else begin
               tmo_d = tmo_q + 16'd1;
            end
            // A stray ID is still consumed (ready is high); flag it.
            if (result_valid_i && result_id_i != id_q) id_err_d = 1'b1;
         end
         ST_RESP: begin
            if (rsp_ready_i) begin
               id_d    = id_q + 1'b1;
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q  <= ST_IDLE;
         status_q <= STATUS_OK;
         id_q     <= '0;
         tmo_q    <= 16'd0;
         instr_q  <= 32'd0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         kill_q   <= 1'b0;
         accept_q <= 1'b0;
         wb_q     <= 1'b0;
         rd_q     <= 5'd0;
         data_q   <= '0;
         we_q     <= 1'b0;
         id_err_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         status_q <= status_d;
         id_q     <= id_d;
         tmo_q    <= tmo_d;
         instr_q  <= instr_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         kill_q   <= kill_d;
         accept_q <= accept_d;
         wb_q     <= wb_d;
         rd_q     <= rd_d;
         data_q   <= data_d;
         we_q     <= we_d;
         id_err_q <= id_err_d;
      end
   end

   // Data outputs are gated by state so they read 0 outside their phase.
   assign st_issue    = (state_q == ST_ISSUE);
   assign st_commit   = (state_q == ST_COMMIT);
   assign st_wait     = (state_q == ST_WAIT_RESULT);
   assign st_resp     = (state_q == ST_RESP);
   assign commit_kill = ~accept_q | kill_q;

   assign req_ready_o      = (state_q == ST_IDLE);
   assign issue_valid_o    = st_issue;
   assign issue_instr_o    = st_issue ? instr_q : 32'd0;
   assign issue_id_o       = st_issue ? id_q : '0;
   assign issue_rs_o       = st_issue ? {rs2_q, rs1_q} : '0;
   assign issue_rs_valid_o = {2{st_issue}};
   assign commit_valid_o   = st_commit;
   assign commit_id_o      = st_commit ? id_q : '0;
   assign commit_kill_o    = st_commit & commit_kill;
   assign result_ready_o   = st_wait;
   assign rsp_valid_o      = st_resp;
   assign rsp_status_o     = st_resp ? status_q : 2'd0;
   assign rsp_rd_o         = st_resp ? rd_q : 5'd0;
   assign rsp_data_o       = st_resp ? data_q : '0;
   assign rsp_we_o         = st_resp & we_q;
   assign id_err_o         = id_err_q;

endmodule

// File: tb/tb_xif_offload_initiator.sv
// Scoreboard bench: a coprocessor stub answers the XIF side, a monitor checks
// commits and responses against expectations queued by the stimulus.
module tb_xif_offload_initiator;
   import xif_initiator_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i, req_ready_o, req_kill_i;
   logic [31:0] req_instr_i, req_rs1_i, req_rs2_i;
   logic        issue_valid_o, issue_ready_i, issue_accept_i, issue_writeback_i;
   logic [31:0] issue_instr_o;
   logic [3:0]  issue_id_o;
   logic [63:0] issue_rs_o;
   logic [1:0]  issue_rs_valid_o;
   logic        commit_valid_o, commit_kill_o;
   logic [3:0]  commit_id_o;
   logic        result_valid_i, result_ready_o, result_we_i;
   logic [3:0]  result_id_i;
   logic [31:0] result_data_i;
   logic [4:0]  result_rd_i;
   logic        rsp_valid_o, rsp_ready_i, rsp_we_o, id_err_o;
   logic [1:0]  rsp_status_o;
   logic [4:0]  rsp_rd_o;
   logic [31:0] rsp_data_o;

   xif_offload_initiator #(
      .X_ID_WIDTH(4), .X_RFR_WIDTH(32), .X_RFW_WIDTH(32), .TIMEOUT_CYCLES(8)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_instr_i(req_instr_i),
      .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_kill_i(req_kill_i),
      .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i), .issue_instr_o(issue_instr_o),
      .issue_id_o(issue_id_o), .issue_rs_o(issue_rs_o), .issue_rs_valid_o(issue_rs_valid_o),
      .issue_accept_i(issue_accept_i), .issue_writeback_i(issue_writeback_i),
      .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_kill_o(commit_kill_o),
      .result_valid_i(result_valid_i), .result_ready_o(result_ready_o), .result_id_i(result_id_i),
      .result_data_i(result_data_i), .result_rd_i(result_rd_i), .result_we_i(result_we_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_status_o(rsp_status_o),
      .rsp_rd_o(rsp_rd_o), .rsp_data_o(rsp_data_o), .rsp_we_o(rsp_we_o), .id_err_o(id_err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [1:0]  status;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        we;
      int          waits;
   } exp_rsp_t;

   typedef struct {
      logic [3:0] id;
      logic       kill;
   } exp_commit_t;

   exp_rsp_t    rq[$];
   exp_commit_t cq[$];

   int checks = 0;
   int errors = 0;
   int wait_cnt = 0;
   int errp_cnt = 0;
   logic [3:0] exp_id = 4'd0;

   int cop_stall = 0;
   bit cop_no_result = 1'b0;
   bit cop_bad_id = 1'b0;

   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] mk_esi(input logic [4:0] rd);
      return {2'b00, FUNCT5_AES32ESI, 5'd2, 5'd1, FUNCT3_AES32, rd, OPCODE_OP};
   endfunction

   // Monitor: commits, responses, WAIT_RESULT occupancy and id_err pulses.
   initial begin
      exp_commit_t c;
      exp_rsp_t    r;
      forever begin
         @(negedge clk_i);
         if (rst_ni !== 1'b1) begin
            wait_cnt = 0;
         end else begin
            if (result_ready_o) wait_cnt++;
            if (id_err_o) errp_cnt++;
            if (commit_valid_o) begin
               if (cq.size() == 0) chk("commit_unexpected", 192'd1, 192'd0);
               else begin
                  c = cq.pop_front();
                  chk("commit_id", 192'(commit_id_o), 192'(c.id));
                  chk("commit_kill", 192'(commit_kill_o), 192'(c.kill));
               end
            end
            if (rsp_valid_o && rsp_ready_i) begin
               if (rq.size() == 0) chk("rsp_unexpected", 192'd1, 192'd0);
               else begin
                  r = rq.pop_front();
                  chk("rsp_status", 192'(rsp_status_o), 192'(r.status));
                  chk("rsp_we", 192'(rsp_we_o), 192'(r.we));
                  chk("rsp_data", 192'(rsp_data_o), 192'(r.data));
                  if (r.status == STATUS_OK) chk("rsp_rd", 192'(rsp_rd_o), 192'(r.rd));
                  chk("wait_cycles", 192'(wait_cnt), 192'(r.waits));
               end
               wait_cnt = 0;
            end
         end
      end
   end

   // Coprocessor stub: accepts AES32 only, returns rs1 ^ 0x63 (aes32esi, bs=0, rs2=0).
   initial begin
      logic [102:0] snap;
      logic [3:0]   c_id;
      logic [31:0]  c_instr, c_rs1;
      logic         acc;
      issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0;
      result_valid_i = 0; result_id_i = 0; result_data_i = 0; result_rd_i = 0; result_we_i = 0;
      forever begin
         @(posedge clk_i); #1;
         if (rst_ni === 1'b1 && issue_valid_o) begin
            snap = {issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o};
            chk("issue_rs_valid", 192'(issue_rs_valid_o), 192'(2'b11));
            for (int k = 0; k < cop_stall; k++) begin
               @(posedge clk_i); #1;
               chk("issue_stable",
                   192'({issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o, issue_rs_valid_o}),
                   192'(snap));
            end
            c_id = issue_id_o; c_instr = issue_instr_o; c_rs1 = issue_rs_o[31:0];
            acc = is_aes32(c_instr);
            issue_ready_i = 1; issue_accept_i = acc; issue_writeback_i = acc;
            @(posedge clk_i); #1;
            issue_ready_i = 0; issue_accept_i = 0; issue_writeback_i = 0;
            if (acc && !commit_kill_o && !cop_no_result) begin
               @(posedge clk_i); #1;
               if (cop_bad_id) begin
                  result_valid_i = 1; result_id_i = 4'(c_id + 4'd1);
                  result_data_i = 32'hDEADBEEF; result_rd_i = 5'd31; result_we_i = 1;
                  @(posedge clk_i); #1;
               end
               result_valid_i = 1; result_id_i = c_id;
               result_data_i = c_rs1 ^ 32'h63; result_rd_i = c_instr[11:7]; result_we_i = 1;
               @(posedge clk_i); #1;
               result_valid_i = 0; result_id_i = 0; result_data_i = 0; result_rd_i = 0; result_we_i = 0;
            end
         end
      end
   end

   task automatic send_req(input logic [31:0] instr, input logic [31:0] rs1, input logic kill);
      int n = 0;
      while (!req_ready_o && n < 50) begin @(posedge clk_i); #1; n++; end
      chk("req_ready_wait", 192'(req_ready_o), 192'd1);
      req_valid_i = 1; req_instr_i = instr; req_rs1_i = rs1; req_rs2_i = 32'd0; req_kill_i = kill;
      @(posedge clk_i); #1;
      req_valid_i = 0; req_instr_i = 0; req_rs1_i = 0; req_kill_i = 0;
   endtask

   task automatic do_txn(input logic [31:0] instr, input logic [31:0] rs1, input logic kill,
                         input logic ckill, input logic [1:0] st, input logic [31:0] data,
                         input logic we, input int waits, input int stall, input int rstall,
                         input bit no_res, input bit bad_id, input int exp_lat);
      exp_rsp_t     r;
      logic [39:0]  snap;
      int           lat;
      cop_stall = stall; cop_no_result = no_res; cop_bad_id = bad_id;
      cq.push_back('{id: exp_id, kill: ckill});
      r.status = st; r.rd = instr[11:7]; r.data = data; r.we = we; r.waits = waits;
      rq.push_back(r);
      send_req(instr, rs1, kill);
      lat = 1;
      while (!rsp_valid_o && lat < 60) begin @(posedge clk_i); #1; lat++; end
      if (!rsp_valid_o) begin
         chk("rsp_timeout", 192'd0, 192'd1);
         return;
      end
      if (exp_lat > 0) chk("latency", 192'(lat), 192'(exp_lat));
      snap = {rsp_valid_o, rsp_status_o, rsp_rd_o, rsp_data_o};
      for (int k = 0; k < rstall; k++) begin
         @(posedge clk_i); #1;
         chk("rsp_stable", 192'({rsp_valid_o, rsp_status_o, rsp_rd_o, rsp_data_o, rsp_we_o}),
             192'({snap, we}));
      end
      rsp_ready_i = 1;
      @(posedge clk_i); #1;
      rsp_ready_i = 0;
      exp_id = 4'(exp_id + 4'd1);
   endtask

   initial begin
      int e0;
      int n;
      rst_ni = 0; req_valid_i = 0; req_instr_i = 0; req_rs1_i = 0; req_rs2_i = 0;
      req_kill_i = 0; rsp_ready_i = 0;
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_outs_zero", 192'(|{issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o,
          issue_rs_valid_o, commit_valid_o, commit_id_o, commit_kill_o, result_ready_o,
          rsp_valid_o, rsp_status_o, rsp_rd_o, rsp_data_o, rsp_we_o, id_err_o}), 192'd0);
      chk("reset_req_ready", 192'(req_ready_o), 192'd1);
      rst_ni = 1;
      @(posedge clk_i); #1;

      // aes32esi x3, rs1=rs2=0: minimum latency path.
      do_txn(32'h222081B3, 32'h0, 0, 0, STATUS_OK, 32'h63, 1, 1, 0, 0, 0, 0, 4);
      // Non-AES instruction rejected by the coprocessor.
      do_txn(32'h00000013, 32'h0, 0, 1, STATUS_ILLEGAL, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      // Flushed legal instruction; the next one carries ID+1 (checked at its commit).
      do_txn(32'h222081B3, 32'h0, 1, 1, STATUS_KILLED, 32'h0, 0, 0, 0, 0, 0, 0, 0);
      // No result ever: timeout after 8 cycles in WAIT_RESULT.
      do_txn(32'h222081B3, 32'h0, 0, 0, STATUS_TIMEOUT, 32'h0, 0, 8, 0, 0, 1, 0, 0);
      // Issue and response back-pressure.
      do_txn(mk_esi(5'd7), 32'hA5A5A5A5, 0, 0, STATUS_OK, 32'hA5A5A5C6, 1, 1, 5, 3, 0, 0, 9);
      // Stray result ID dropped with an id_err pulse.
      e0 = errp_cnt;
      do_txn(mk_esi(5'd9), 32'h12345678, 0, 0, STATUS_OK, 32'h1234561B, 1, 2, 0, 0, 0, 1, 0);
      chk("id_err_pulses", 192'(errp_cnt - e0), 192'd1);

      // Reset while waiting for a result: abandoned, no response.
      cop_stall = 0; cop_no_result = 1; cop_bad_id = 0;
      cq.push_back('{id: exp_id, kill: 1'b0});
      send_req(mk_esi(5'd4), 32'h0, 0);
      n = 0;
      while (!result_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
      chk("reached_wait", 192'(result_ready_o), 192'd1);
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 0;
      @(posedge clk_i); #1;
      chk("midreset_outs_zero", 192'(|{issue_valid_o, issue_instr_o, issue_id_o, issue_rs_o,
          issue_rs_valid_o, commit_valid_o, commit_id_o, commit_kill_o, result_ready_o,
          rsp_valid_o, rsp_status_o, rsp_rd_o, rsp_data_o, rsp_we_o, id_err_o}), 192'd0);
      chk("midreset_idle", 192'(req_ready_o), 192'd1);
      rst_ni = 1;
      exp_id = 4'd0;
      cop_no_result = 0;
      @(posedge clk_i); #1;

      // 17 back-to-back: IDs 0..15 then wrap to 0.
      for (int i = 0; i < 17; i++) begin
         do_txn(mk_esi(5'((i % 31) + 1)), 32'(i) * 32'h01010101, 0, 0, STATUS_OK,
                (32'(i) * 32'h01010101) ^ 32'h63, 1, 1, 0, 0, 0, 0, 4);
      end

      repeat (4) @(posedge clk_i);
      #1;
      chk("commit_queue_empty", 192'(cq.size()), 192'd0);
      chk("rsp_queue_empty", 192'(rq.size()), 192'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/xif_offload_initiator.md
Name: xif_offload_initiator

Overview:
- CPU-side initiator of the eXtension interface (XIF) issue/commit/result protocol.
- Takes one offload request at a time (instruction plus two operands) from a simple valid/ready request port.
- Drives the XIF issue handshake, issues exactly one commit or kill per issued transaction, and collects the matching result.
- Returns a writeback response with a status code. Used as a bench and SoC driver for XIF coprocessors such as the AES32 unit.

Parameters:
- X_ID_WIDTH, 4, width of the transaction ID; IDs wrap modulo 2^X_ID_WIDTH.
- X_RFR_WIDTH, 32, register-file read operand width.
- X_RFW_WIDTH, 32, register-file write data width.
- TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT_RESULT before aborting; range 1..65535.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset
- req_valid_i  in  1  offload request valid
- req_ready_o  out  1  request accepted (IDLE only)
- req_instr_i  in  32  instruction word
- req_rs1_i, req_rs2_i  in  X_RFR_WIDTH  operands
- req_kill_i  in  1  kill this transaction at commit (models a flushed speculative instruction)
- issue_valid_o  out  1  XIF issue valid
- issue_ready_i  in  1  XIF issue ready
- issue_instr_o  out  32  issued instruction
- issue_id_o  out  X_ID_WIDTH  transaction ID
- issue_rs_o  out  2*X_RFR_WIDTH  {rs2, rs1}
- issue_rs_valid_o  out  2  operand valid
- issue_accept_i  in  1  coprocessor accepts the instruction
- issue_writeback_i  in  1  coprocessor will write rd
- commit_valid_o  out  1  commit strobe
- commit_id_o  out  X_ID_WIDTH  committed ID
- commit_kill_o  out  1  kill flag
- result_valid_i  in  1  result valid
- result_ready_o  out  1  result ready
- result_id_i  in  X_ID_WIDTH  result ID
- result_data_i  in  X_RFW_WIDTH  result data
- result_rd_i  in  5  destination register
- result_we_i  in  1  write enable
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response ready
- rsp_status_o  out  2  0 OK, 1 ILLEGAL, 2 KILLED, 3 TIMEOUT
- rsp_rd_o  out  5  destination register
- rsp_data_o  out  X_RFW_WIDTH  writeback data
- rsp_we_o  out  1  writeback enable
- id_err_o  out  1  one-cycle pulse when a result with an unexpected ID is dropped

Behaviour:
- Reset (synchronous, rst_ni low at a clk_i edge):
  - State returns to IDLE; ID counter and timeout counter clear to 0.
  - All valid, strobe and pulse outputs go to 0; all data outputs go to 0.
  - A transaction in flight when reset asserts is abandoned: no commit is issued and no response is produced.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i: capture instr, rs1, rs2 and kill; tag the transaction with the current ID; go to ISSUE.
- ISSUE:
  - issue_valid_o=1 and issue_rs_valid_o=2'b11; issue_* outputs are held stable until issue_ready_i.
  - On handshake: latch accept and writeback; go to COMMIT.
- COMMIT:
  - Exactly one cycle: commit_valid_o=1, commit_id_o = captured ID, commit_kill_o = ~accept | kill.
  - If the kill condition holds, go to RESP with status ILLEGAL (accept=0, which takes priority) or KILLED.
  - Otherwise clear the timeout counter and go to WAIT_RESULT.
- WAIT_RESULT:
  - result_ready_o=1.
  - result_valid_i with result_id_i == ID: capture data, rd, and (result_we_i & writeback); status OK; go to RESP.
  - result_valid_i with a mismatched ID: the result is consumed and dropped, id_err_o pulses, and the block stays in WAIT_RESULT.
  - The timeout counter increments once per cycle. When it reaches TIMEOUT_CYCLES-1 with no matching result, go to RESP with status TIMEOUT and rsp_we_o=0.
  - If a matching result arrives in the same cycle the timeout is reached, the result wins.
- RESP:
  - rsp_valid_o=1 with all rsp_* outputs stable until rsp_ready_i.
  - For non-OK status, rsp_we_o=0 and rsp_data_o=0.
  - On handshake: ID increments (wrapping 2^X_ID_WIDTH-1 -> 0); go to IDLE.
- Latency:
  - Minimum request to response is 4 cycles: IDLE, ISSUE, COMMIT, then WAIT_RESULT with a same-cycle result.
  - No new request is accepted until the response handshake completes.

Decomposition:
- xif_initiator_pkg holds:
  - state_e {IDLE, ISSUE, COMMIT, WAIT_RESULT, RESP} and status_e {OK, ILLEGAL, KILLED, TIMEOUT};
  - AES32 encoding constants: OPCODE_OP=7'b0110011, FUNCT3_AES32=3'b000, and the funct5 values 10001/10011/10101/10111.
- No sub-module; the timeout counter stays inline.

Test Plan:
- aes32esi against the AES coprocessor:
  - Stimulus: instr 0x222081B3 (bs=0, rd=x3), rs1=0, rs2=0.
  - Response: one issue and one commit with kill=0, then status OK, rd=3, data=0x00000063, we=1.
- Illegal instruction:
  - Stimulus: instr 0x00000013, so accept=0.
  - Response: commit_kill_o=1, status ILLEGAL, rsp_we_o=0, no result_ready_o asserted.
- Kill: req_kill_i=1 on a valid aes32 instruction -> commit_kill_o=1, status KILLED, and the next request is tagged ID+1.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8 and the coprocessor never asserts result_valid_i.
  - Response: status TIMEOUT after exactly 8 cycles in WAIT_RESULT.
- ID handling:
  - Stimulus: 17 back-to-back transactions, plus one injected result carrying the wrong ID.
  - Response: IDs run 0..15 then 0; the wrong-ID result produces an id_err_o pulse and is dropped, and the correct result still completes.
- Back-pressure and reset:
  - issue_ready_i low for 5 cycles -> issue outputs stay stable throughout.
  - rsp_ready_i low for 3 cycles -> response outputs stay stable throughout.
  - rst_ni low while in WAIT_RESULT -> state IDLE, all outputs 0, ID 0.
